// File: rtl/spectrum_pkg.sv
// Shared types and helpers for the spectrum peak-hold block.
package spectrum_pkg;
  localparam int PEAK_W   = 16;
  localparam int BIN_W    = 10;
  localparam int HEIGHT_W = 9;
  localparam int NUM_BINS = 1 << BIN_W;
  localparam int LOG_W    = $clog2(PEAK_W + 1);

  typedef logic [PEAK_W-1:0]   peak_t;
  typedef logic [HEIGHT_W-1:0] height_t;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } sweep_e;

  function automatic peak_t sat_sub(
    input peak_t a,
    input peak_t b
  );
    return (a > b) ? a - b : '0;
  endfunction

  // Position of the leading one plus one; zero input gives zero.
  function automatic logic [LOG_W-1:0] lead_one(
    input peak_t x
  );
    logic [LOG_W-1:0] r;
    r = '0;
    for (int i = 0; i < PEAK_W; i++) begin
      if (x[i]) r = LOG_W'(i + 1);
    end
    return r;
  endfunction
endpackage

// File: rtl/spectrum_peak_ram.sv
// Simple dual-port peak memory, one write port and one
// synchronous read port with 1-cycle latency.
module spectrum_peak_ram
  import spectrum_pkg::*;
#(
  parameter int ADDR_W = BIN_W,
  parameter int DATA_W = PEAK_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/spectrum_peak_hold.sv
// Per-bin decaying peak hold between FFT and VRAM write port.
// Define SPECTRUM_PEAK_HOLD_LOG_SCALE_EN for log-scale bar heights.
module spectrum_peak_hold
  import spectrum_pkg::*;
#(
  parameter int WORD_SIZE    = PEAK_W,
  parameter int BIN_BITS     = BIN_W,
  parameter int HEIGHT_BITS  = HEIGHT_W,
  parameter int HEIGHT_SHIFT = 7,
  parameter int DECAY_STEP   = 16,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                   inClock,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [BIN_BITS-1:0]    inBin,
  input  logic [WORD_SIZE-1:0]   inData,
  output logic                   outValid,
  output logic [BIN_BITS-1:0]    outBin,
  output logic [HEIGHT_BITS-1:0] outHeight,
  output logic                   clearing
);

  localparam int FW =
    (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int HMAX = (1 << HEIGHT_BITS) - 1;
  localparam logic [BIN_BITS-1:0] LAST_BIN = '1;
  localparam logic [FW-1:0] LAST_FRAME =
    FW'(DECAY_FRAMES - 1);

  sweep_e              state_q, state_d;
  logic [BIN_BITS-1:0] clr_addr_q, clr_addr_d;
  logic [FW-1:0]       frame_q, frame_d;

  logic                s1_valid_q, s1_valid_d;
  logic [BIN_BITS-1:0] s1_bin_q, s1_bin_d;
  peak_t               s1_data_q, s1_data_d;
  logic                s1_decay_q, s1_decay_d;
  logic                s1_fwd_q, s1_fwd_d;
  peak_t               s1_fwd_val_q, s1_fwd_val_d;

  logic                   out_valid_q, out_valid_d;
  logic [BIN_BITS-1:0]    out_bin_q, out_bin_d;
  logic [HEIGHT_BITS-1:0] out_height_q, out_height_d;

  logic                ram_we;
  logic [BIN_BITS-1:0] ram_waddr;
  peak_t               ram_wdata;
  peak_t               ram_rdata;

  logic                   accept;
  peak_t                  peak_cur;
  peak_t                  decayed;
  peak_t                  new_peak;
  logic [HEIGHT_BITS-1:0] height;

  assign clearing = (state_q == ST_CLEAR);
  assign inReady  = (state_q == ST_RUN);
  assign accept   = inValid && inReady;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_BIN) state_d = ST_RUN;
    end
  end

  always_comb begin
    frame_d = frame_q;
    if (accept && inBin == LAST_BIN) begin
      frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
    end
  end

  // Stage 1 sees a stale RAM read when the previous sample hit the same bin.
  always_comb begin
    peak_cur = s1_fwd_q ? s1_fwd_val_q : ram_rdata;
    decayed  = s1_decay_q
             ? sat_sub(peak_cur, peak_t'(DECAY_STEP))
             : peak_cur;
    new_peak = (s1_data_q > decayed) ? s1_data_q : decayed;
  end

`ifdef SPECTRUM_PEAK_HOLD_LOG_SCALE_EN
  logic [LOG_W-1:0] log_pos;
  logic [31:0]      log_h;

  always_comb begin
    log_pos = lead_one(new_peak);
    log_h   = 32'(log_pos) << (HEIGHT_BITS - LOG_W);
    height  = (log_h > 32'(HMAX))
            ? '1 : log_h[HEIGHT_BITS-1:0];
  end
`else
  peak_t lin_h;

  always_comb begin
    lin_h  = new_peak >> HEIGHT_SHIFT;
    height = (lin_h > peak_t'(HMAX))
           ? '1 : lin_h[HEIGHT_BITS-1:0];
  end
`endif

  always_comb begin
    s1_valid_d   = accept;
    s1_bin_d     = inBin;
    s1_data_d    = inData;
    s1_decay_d   = (frame_q == LAST_FRAME);
    s1_fwd_d     = s1_valid_q && (s1_bin_q == inBin);
    s1_fwd_val_d = new_peak;
  end

  always_comb begin
    out_valid_d  = s1_valid_q;
    out_bin_d    = out_bin_q;
    out_height_d = out_height_q;
    if (s1_valid_q) begin
      out_bin_d    = s1_bin_q;
      out_height_d = height;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_bin_q;
    ram_wdata = new_peak;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = '0;
      end else begin
        ram_we = s1_valid_q;
      end
    end
  end

  always_ff @(posedge inClock) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      frame_q      <= '0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bin_q    <= '0;
      out_height_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      frame_q      <= frame_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_bin_q    <= out_bin_d;
      out_height_q <= out_height_d;
    end
  end

  always_ff @(posedge inClock) begin
    s1_bin_q     <= s1_bin_d;
    s1_data_q    <= s1_data_d;
    s1_decay_q   <= s1_decay_d;
    s1_fwd_q     <= s1_fwd_d;
    s1_fwd_val_q <= s1_fwd_val_d;
  end

  spectrum_peak_ram #(
    .ADDR_W(BIN_BITS),
    .DATA_W(WORD_SIZE)
  ) u_ram (
    .clk  (inClock),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(inBin),
    .rdata(ram_rdata)
  );

  assign outValid  = out_valid_q;
  assign outBin    = out_bin_q;
  assign outHeight = out_height_q;

endmodule

// File: tb/tb_spectrum_peak_hold.sv
// Scoreboard bench for spectrum_peak_hold.
module tb_spectrum_peak_hold;

`ifdef SPECTRUM_PEAK_HOLD_LOG_SCALE_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  localparam int DF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [9:0] inBin = '0;
  logic [15:0] inData = '0;
  logic       outValid;
  logic [9:0] outBin;
  logic [8:0] outHeight;
  logic       clearing;

  typedef struct {
    int cyc;
    int bin;
    int h;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mpeak[1024];
  int   mframe = 0;

  spectrum_peak_hold #(
    .WORD_SIZE(16), .BIN_BITS(10), .HEIGHT_BITS(9),
    .HEIGHT_SHIFT(7), .DECAY_STEP(16), .DECAY_FRAMES(DF)
  ) dut (
    .inClock(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .inBin(inBin), .inData(inData),
    .outValid(outValid), .outBin(outBin),
    .outHeight(outHeight), .clearing(clearing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int model_h(input int p);
    int m;
    int h;
    if (LOG) begin
      m = 0;
      for (int i = 0; i < 16; i++) if (p[i]) m = i + 1;
      h = m << 4;
    end else begin
      h = p >> 7;
    end
    return (h > 511) ? 511 : h;
  endfunction

  function automatic int model_step(input int bin, input int data);
    int p;
    p = mpeak[bin];
    if (mframe == DF - 1) p = (p > 16) ? p - 16 : 0;
    if (data > p) p = data;
    mpeak[bin] = p;
    if (bin == 1023) mframe = (mframe == DF - 1) ? 0 : mframe + 1;
    return model_h(p);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mpeak[i] = 0;
    mframe = 0;
  endtask

  always @(negedge clk) begin
    if (outValid === 1'b1) begin
      n_assert++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out bin=%0d height=%0d cyc=%0d",
                 outBin, outHeight, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (outBin !== 10'(e.bin) || outHeight !== 9'(e.h) ||
            cyc != e.cyc) begin
          n_fail++;
          $display("FAIL out bin=%0d/%0d height=%0d/%0d cyc=%0d/%0d (got/exp)",
                   outBin, e.bin, outHeight, e.h, cyc, e.cyc);
        end
      end
    end
  end

  // hexp >= 0 overrides the model with a hand-derived height.
  task automatic send(input int bin, input int data, input int hexp);
    exp_t e;
    int   mh;
    @(posedge clk);
    #1;
    n_assert++;
    if (inReady !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready got=%b exp=1 bin=%0d", inReady, bin);
    end
    inValid = 1'b1;
    inBin   = 10'(bin);
    inData  = 16'(data);
    mh = model_step(bin, data);
    e.cyc = cyc + 2;
    e.bin = bin;
    e.h   = (hexp >= 0) ? hexp : mh;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int k;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    k = 0;
    while (sbq.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    n_assert++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_sweep();
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (clearing === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    inValid = 1'b0;
    n_assert++;
    if (cnt != 1024) begin
      n_fail++;
      $display("FAIL sweep_len got=%0d exp=1024", cnt);
    end
    n_assert++;
    if (inReady !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_sweep got=%b exp=1", inReady);
    end
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (outValid !== 1'b0 || outBin !== 10'd0 || outHeight !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_out v=%b bin=%0d h=%0d exp=0/0/0",
               outValid, outBin, outHeight);
    end
    n_assert++;
    if (inReady !== 1'b0 || clearing !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctl ready=%b clearing=%b exp=0/1",
               inReady, clearing);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    inValid = 1'b1;
    inBin   = 10'd9;
    inData  = 16'hFFFF;
    wait_sweep();
  endtask

  task automatic test_zero_sample();
    send(5, 0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    send(3, 16'h4000, LOG ? -1 : 128);
    send(3, 16'h1000, LOG ? -1 : 128);
    drain();
  endtask

  task automatic test_decay();
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 1024; b++) begin
        send(b, 0, (b == 3 && !LOG) ? 128 : -1);
      end
    end
    for (int b = 0; b < 1024; b++) begin
      send(b, 0, (b == 3 && !LOG) ? 127 : -1);
    end
    drain();
  endtask

  task automatic test_saturation();
    send(7, 16'hFFFF, LOG ? -1 : 511);
    send(8, 8, 0);
    for (int i = 0; i < 3; i++) send(1023, 0, -1);
    send(8, 0, 0);
    send(8, 0, 0);
    drain();
  endtask

  task automatic test_height();
    send(20, 16'h0100, LOG ? 144 : 2);
    send(21, 0, 0);
    send(22, 16'h0C80, LOG ? 192 : 25);
    drain();
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    inValid = 1'b1;
    inBin   = 10'd9;
    inData  = 16'h8000;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_sweep();
    send(9, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_zero_sample();
    test_back_to_back();
    test_decay();
    test_saturation();
    test_height();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_hold.md
Name: spectrum_peak_hold

Overview:
- Sits directly downstream of the FFT stage and upstream of the VGA generator's VRAM write port.
- Takes one FFT bin magnitude per accepted sample, keeps a per-bin peak value that decays over time, and emits a bar height per bin.
- Replaces the raw FFT output as the VRAM write data, so displayed bars rise instantly and fall slowly.

Parameters:
- WORD_SIZE, 16: width of the incoming unsigned magnitude and of the stored peak.
- BIN_BITS, 10: bin index width; the block holds 2^BIN_BITS bins.
- HEIGHT_BITS, 9: output bar height width.
- HEIGHT_SHIFT, 7: right shift applied to the peak before height saturation.
- DECAY_STEP, 16: amount subtracted from a peak on a decay frame.
- DECAY_FRAMES, 4: a decay frame occurs once every DECAY_FRAMES frames; legal range is 1 or more.

Ports:
- inClock  in  1  block clock (same domain as the FFT output).
- reset  in  1  synchronous, active-high.
- inValid  in  1  inBin/inData qualify this cycle.
- inReady  out  1  block accepts a sample; low during the clear sweep.
- inBin  in  BIN_BITS  bin index of the sample.
- inData  in  WORD_SIZE  unsigned bin magnitude.
- outValid  out  1  outBin/outHeight qualify this cycle.
- outBin  out  BIN_BITS  bin index, drives vramWriteAddr.
- outHeight  out  HEIGHT_BITS  bar height, drives vramInData.
- clearing  out  1  high while the peak memory clear sweep runs.

Behaviour:
- Clock and reset: single clock inClock; reset is synchronous and active-high.
- Reset values: outValid=0, outBin=0, outHeight=0, inReady=0, clearing=1, frame counter=0, pipeline valids=0.
- Clear sweep: starts on the first cycle after reset is deasserted. Writes 0 to every peak entry, 0 to 2^BIN_BITS-1, one entry per cycle. After the last entry: clearing=0 and inReady=1 on the next cycle.
- inValid while inReady=0: ignored, produces no output.
- Reset asserted mid-operation: flushes the pipeline (no outValid) and restarts the sweep from entry 0.
- Accept: a sample is accepted on any cycle with inValid&&inReady. There is no backpressure after clear, so inReady stays 1.
- Pipeline stage 0 (accept cycle): read peak[inBin]; latch inBin, inData, and decayNow = (frameCount==DECAY_FRAMES-1).
- Pipeline stage 1:
  - decayed = decayNow ? max(peak - DECAY_STEP, 0) : peak, using a saturating subtract.
  - newPeak = max(inData, decayed).
  - Write newPeak to peak[bin].
  - Register the outputs.
- Latency: outValid is asserted exactly 2 cycles after acceptance and stays high for 1 cycle per accepted sample. Order is preserved, full throughput.
- Hazard: if stage 1 writes the same bin that stage 0 is reading in the same cycle, stage 0 uses the forwarded newPeak, not the stale memory value. Back-to-back identical bins must behave as if processed serially.
- Height: outHeight = min(newPeak >> HEIGHT_SHIFT, 2^HEIGHT_BITS-1).
- Frame counter:
  - Increments when an accepted sample has inBin == 2^BIN_BITS-1.
  - Wraps from DECAY_FRAMES-1 to 0.
  - Bins may arrive in any order; only the last-index bin marks a frame boundary.
- decayNow for the last bin of a frame uses the counter value before the increment.
- DECAY_FRAMES=1: every frame decays.

Optional Feature:
- Macro SPECTRUM_PEAK_HOLD_LOG_SCALE_EN.
- Defined: outHeight = (position of the leading one of newPeak + 1) << (HEIGHT_BITS - clog2(WORD_SIZE+1)), saturated to 2^HEIGHT_BITS-1; newPeak=0 gives 0. HEIGHT_SHIFT is unused. The log-scale display is computed combinationally in stage 1, so latency is unchanged.
- Undefined: linear shift-and-saturate as described under Behaviour.

Decomposition:
- Shared package spectrum_pkg holds:
  - the bin count constant;
  - the peak word typedef;
  - the height typedef;
  - saturating-subtract and leading-one functions.
- One sub-module is natural: spectrum_peak_ram, a simple dual-port RAM of 2^BIN_BITS x WORD_SIZE with a 1-cycle synchronous read. Forwarding stays in the top block.

Test Plan:
- Reset, then wait: clearing=1 for exactly 1024 cycles, then inReady=1. Sample bin 5 with data 0 → outHeight=0, 2 cycles later.
- Bin 3 with data 0x4000, then bin 3 with data 0x1000 on the next cycle, frameCount=0 → outHeights 128 then 128 (the peak is held via forwarding).
- Decay: DECAY_FRAMES=4, bin 3 held at 0x4000. Feed 3 full frames of zeros → peak unchanged. On the 4th frame, bin 3 with data 0 → peak 0x3FF0, outHeight 127.
- Saturation: bin 7 with data 0xFFFF → outHeight 511. Decay of a peak of 8 with DECAY_STEP=16 → 0, not a wrap.
- Reset asserted 1 cycle after accepting bin 9 → no outValid for bin 9. Sweep restarts and peak[9] reads 0 afterwards.
- With SPECTRUM_PEAK_HOLD_LOG_SCALE_EN defined, data 0x0100 → outHeight = 9 << 4 = 144; data 0 → 0.
